// File: rtl/cmp_feeder.sv
// -----------------------------------------------------------------------------
// cmp_feeder
//   Upstream operand sequencer for the combinational comparator "red".
//   Operand pairs are buffered in a small FIFO and driven one at a time onto
//   the comparator inputs (palabraA/palabraB). After SETTLE cycles the
//   comparator output Z is sampled. The result is then presented together
//   with the operands that produced it, using a valid/ready handshake.
//
// Parameters
//   WIDTH  : operand width, must match the comparator word width
//   DEPTH  : FIFO entries, power of two, >= 2
//   SETTLE : cycles from driving operands to sampling Z, >= 1
//
// Ports
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    : operand-pair input handshake (in_ready = !full)
//   in_a, in_b           : operands A and B
//   palabraA, palabraB   : registered operands driven to the comparator
//   Z                    : comparator result
//   res_valid/res_ready  : result output handshake
//   res_z, res_a, res_b  : captured Z and the operand pair belonging to it
//   res_count            : (only with CMP_FEEDER_COUNT_EN) saturating 8-bit
//                          count of completed result handshakes
//
// Optional feature macro: CMP_FEEDER_COUNT_EN
// -----------------------------------------------------------------------------
module cmp_feeder #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] palabraA,
  output logic [WIDTH-1:0] palabraB,
  input  logic             Z,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_z,
  output logic [WIDTH-1:0] res_a,
`ifdef CMP_FEEDER_COUNT_EN
  output logic [WIDTH-1:0] res_b,
  output logic [7:0]       res_count
`else
  output logic [WIDTH-1:0] res_b
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 next_state_s;
  logic [2*WIDTH-1:0]     mem_r [DEPTH];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [AW:0]            count_r;
  logic [CW-1:0]          cnt_r;
  logic                   full_s;
  logic                   empty_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   capture_s;
  logic                   release_s;
  logic                   cnt_dec_s;

  // Full/empty come straight from the occupancy register, so a freshly
  // pushed pair is never visible to the pop logic in the same cycle.
  assign full_s   = (count_r == DEPTH_C);
  assign empty_s  = (count_r == {(AW+1){1'b0}});
  assign in_ready = ~full_s;
  // A push is refused while full, even when a pop happens in the same cycle.
  assign push_s   = in_valid & ~full_s;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) next_state_s = DRIVE;
        else          next_state_s = IDLE;
      end
      DRIVE: begin
        if (cnt_r == CNT_ZERO) next_state_s = HOLD;
        else                   next_state_s = DRIVE;
      end
      HOLD: begin
        if (res_ready) begin
          // Back-to-back: go straight to DRIVE when more work is queued
          if (!empty_s) next_state_s = DRIVE;
          else          next_state_s = IDLE;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM output decode: datapath strobes for pop, Z capture, result release
  always_comb begin
    pop_s     = 1'b0;
    capture_s = 1'b0;
    release_s = 1'b0;
    cnt_dec_s = 1'b0;
    case (state_r)
      IDLE: begin
        pop_s = ~empty_s;
      end
      DRIVE: begin
        if (cnt_r == CNT_ZERO) capture_s = 1'b1;
        else                   cnt_dec_s = 1'b1;
      end
      HOLD: begin
        release_s = res_ready;
        pop_s     = res_ready & ~empty_s;
      end
      default: begin
        pop_s = 1'b0;
      end
    endcase
  end

  // FIFO storage (contents need no reset; occupancy is tracked by count_r)
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_a, in_b};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Comparator operand registers and settle counter; operands only move on a
  // pop, so Z is stable for the whole DRIVE window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      palabraA <= {WIDTH{1'b0}};
      palabraB <= {WIDTH{1'b0}};
      cnt_r    <= CNT_ZERO;
    end else begin
      if (pop_s) begin
        {palabraA, palabraB} <= mem_r[rd_ptr_r];
        cnt_r                <= CNT_LOAD;
      end else if (cnt_dec_s) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end
  end

  // Result registers: capture at the end of DRIVE, hold until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_z     <= 1'b0;
      res_a     <= {WIDTH{1'b0}};
      res_b     <= {WIDTH{1'b0}};
    end else begin
      if (capture_s) begin
        res_valid <= 1'b1;
        res_z     <= Z;
        res_a     <= palabraA;
        res_b     <= palabraB;
      end else if (release_s) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef CMP_FEEDER_COUNT_EN
  // Saturating count of completed result handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_count <= 8'd0;
    end else begin
      if (res_valid && res_ready && (res_count != 8'hFF)) begin
        res_count <= res_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: doc/cmp_feeder.md
Name: cmp_feeder

Overview:
- Upstream operand sequencer for the combinational 4-bit comparator `red` (palabraA, palabraB -> Z).
- Buffers operand pairs in a small FIFO and drives one pair at a time onto the comparator inputs.
- Waits a programmable settle time, then samples Z and presents the result with a valid/ready handshake.
- Turns the comparator into a streamed, flow-controlled pipeline stage.

Parameters:
- WIDTH, 4, operand width in bits; must match the comparator word width.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- SETTLE, 1, cycles between driving operands and sampling Z; >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept; equals !full.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- palabraA  out  WIDTH  registered operand A to the comparator.
- palabraB  out  WIDTH  registered operand B to the comparator.
- Z  in  1  comparator result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_z  out  1  captured Z.
- res_a  out  WIDTH  operand A belonging to res_z.
- res_b  out  WIDTH  operand B belonging to res_z.

Behaviour:
- Reset, asynchronous on rst_n low: state IDLE; FIFO empty, so in_ready=1; all pointers, counters and outputs zero (palabraA, palabraB, res_valid, res_z, res_a, res_b).
- Reset mid-operation discards FIFO contents and any pending result.
- Push: in_valid & in_ready at an edge writes {in_a, in_b} at the write pointer. Pointers wrap modulo DEPTH; a count register distinguishes full from empty.
- Full: in_ready=0, push ignored. A push is refused when full even if a pop happens in the same cycle.
- No bypass: a pair pushed into an empty FIFO is poppable no earlier than the next edge.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- FSM IDLE:
  - If FIFO non-empty: pop head into palabraA/palabraB, cnt <= SETTLE-1, go DRIVE.
  - Else: stay; palabraA/B hold their last values.
- FSM DRIVE:
  - If cnt==0: res_z <= Z, res_a <= palabraA, res_b <= palabraB, res_valid <= 1, go HOLD.
  - Else: cnt <= cnt-1.
- FSM HOLD:
  - res_* remain stable while res_valid=1 and res_ready=0.
  - On res_ready=1: res_valid <= 0. If FIFO non-empty, pop and go DRIVE (back-to-back, no IDLE cycle); else go IDLE.
- Latency with SETTLE=1, FIFO empty, state IDLE:
  - Accept at edge E0.
  - palabraA/B valid after E1.
  - res_valid=1 after E2.
- General latency: SETTLE+1 edges after accept.
- Sustained throughput with res_ready tied high: one result per SETTLE+1 cycles.
- palabraA/B change only on a pop edge, so Z is stable for the whole DRIVE window.

Optional Feature:
- Macro CMP_FEEDER_COUNT_EN.
- Defined: adds output res_count (8 bits). Increments on each res_valid & res_ready handshake, saturates at 255, reset to 0.
- Undefined: no port, no counter logic; all other behaviour identical.

Test Plan:
- Bench stub Z = (palabraA > palabraB) for all scenarios.
- Basic path: after reset push (5,8), res_ready=1 -> res_valid rises 2 cycles after accept with res_z=0, res_a=5, res_b=8; palabraA=5, palabraB=8 one cycle after accept.
- Stream ordering: push (5,8), (12,7), (6,6) back-to-back, res_ready=1 -> results in order z=0, 1, 0 with matching res_a/res_b; one result every 2 cycles.
- Backpressure/full: res_ready=0, push 6 pairs (DEPTH=4) -> first pair popped into HOLD, next 4 fill FIFO, in_ready=0 on the 6th offer and it is not accepted; release res_ready -> exactly 5 results in order.
- Settle timing: SETTLE=3, stub Z delayed by 2 cycles -> res_z still correct; res_valid 4 cycles after accept.
- Reset mid-operation: push 3 pairs, assert rst_n=0 during DRIVE -> immediately res_valid=0, in_ready=1, palabraA=palabraB=0; after release no stale results emerge.
- With CMP_FEEDER_COUNT_EN: 300 handshakes -> res_count=255; reset -> 0.
